voltmeter_sample_ctrl: RTL and testbench
========================================

Name: voltmeter_sample_ctrl

Overview:
- Sequencer for the voltmeter comparator front end and its segment decoder.
- Periodically powers the comparator reference (ref_en), waits for settling, then samples the three raw comparator lines.
- Accepts a sample only once the 3-bit code is stable for STABLE_N consecutive cycles, then loads the held code that drives the display decoder inputs (BoogerA/B/C).
- Provides display hold, busy status and update/miss strobes.

Parameters:
- DIV, 1000: sample-interval prescaler period in clk cycles. Must be ≥ 2.
- SETTLE_CYC, 4: cycles ref_en is high before sampling starts. Must be ≥ 1.
- STABLE_N, 3: consecutive identical samples required to accept a code. Must be ≥ 1.
- MAX_SAMP, 12: maximum cycles spent in SAMPLE before abandoning the measurement. Must be ≥ STABLE_N.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-high.
- en, in, 1: measurement enable.
- hold, in, 1: freeze the displayed code; measurements still run.
- cmp_a, in, 1: raw comparator A (asynchronous).
- cmp_b, in, 1: raw comparator B (asynchronous).
- cmp_c, in, 1: raw comparator C (asynchronous).
- ref_en, out, 1: comparator reference/ladder enable.
- code_a, out, 1: held code bit, drives BoogerA.
- code_b, out, 1: held code bit, drives BoogerB.
- code_c, out, 1: held code bit, drives BoogerC.
- upd, out, 1: one-cycle pulse; held code was just loaded.
- miss, out, 1: one-cycle pulse; measurement abandoned without a stable code.
- busy, out, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; prescaler, settle, sample and match counters 0; sync flops 0; candidate 000.
- Synchronisers:
  - cmp_{a,b,c} each pass through a 2-flop synchroniser that runs continuously.
  - The FSM sees only synchronised values (s = {s_a, s_b, s_c}).
- Prescaler:
  - When en=1, counts 0..DIV-1 and wraps.
  - tick = (count == DIV-1) & en.
  - When en=0, the count clears to 0 and there is no tick.
  - Ticks continue while the FSM is busy; a tick in any state other than IDLE is ignored, not queued.
- FSM states: IDLE, SETTLE, SAMPLE, UPDATE.
  - IDLE: ref_en=0. On tick, go to SETTLE; settle counter = 0.
  - SETTLE: ref_en=1. Counts SETTLE_CYC cycles, then goes to SAMPLE with the sample counter and match counter at 0.
  - SAMPLE: ref_en=1. Each cycle, sample counter +1.
    - If match counter is 0 or s ≠ candidate: candidate ← s, match counter ← 1.
    - Otherwise match counter +1.
    - When the updated match counter equals STABLE_N, go to UPDATE.
    - Otherwise, if the sample counter reaches MAX_SAMP, go to IDLE and pulse miss the next cycle.
    - Stability takes priority over timeout if both occur in the same cycle.
  - UPDATE: ref_en=1, one cycle, then IDLE.
    - On the exiting edge, if hold=0: code_* ← candidate and upd=1 for one cycle.
    - If hold=1: codes unchanged and no upd.
- Latency: with tick high in cycle T, state is SETTLE at T+1, earliest UPDATE at T+SETTLE_CYC+STABLE_N+1, and code/upd visible at T+SETTLE_CYC+STABLE_N+2. Defaults: T+9.
- ref_en is high in exactly SETTLE, SAMPLE and UPDATE.
- busy = (state ≠ IDLE), registered with the state.
- en falling mid-measurement: the FSM returns to IDLE on the next edge. No upd, no miss; codes held; ref_en low the following cycle.
- hold only gates the load of code_*; it does not stop sequencing or miss.
- All 8 code values are accepted; no thermometer-validity filtering.
- rst mid-operation forces all reset values immediately; the displayed code clears to 000.

Test Plan:
- Reset/idle: DIV=16, en=0, cmp=111 → after 100 cycles ref_en=0, busy=0, code=000, no upd/miss.
- Normal measurement: en=1, cmp held at 011 → each period ref_en high for exactly SETTLE_CYC+STABLE_N+1 = 8 cycles; upd pulses once per DIV with code=011, 9 cycles after tick.
- Instability: cmp toggles 001↔011 every cycle during SAMPLE → no upd; miss pulses once after 12 SAMPLE cycles; code unchanged.
- Late stabilisation: cmp=001 for 2 SAMPLE cycles, then 111 steady → upd with code=111 after SAMPLE cycle 5 (2 + STABLE_N).
- Hold: code=011 displayed; set hold=1, cmp=111 → measurements run (ref_en pulses, busy) but code stays 011 and upd stays 0; release hold → next measurement loads 111.
- Abort and reset: drop en during SETTLE → IDLE next edge, no strobes. Assert rst asynchronously mid-SAMPLE → outputs 0 immediately, no clock needed.

Source files
------------

// File: rtl/voltmeter_sample_ctrl.sv
// voltmeter_sample_ctrl: periodic settle/sample/debounce sequencer that loads the held
// 3-bit comparator code driving the segment decoder, with hold, busy and upd/miss strobes.
module voltmeter_sample_ctrl #(
  parameter int DIV        = 1000,
  parameter int SETTLE_CYC = 4,
  parameter int STABLE_N   = 3,
  parameter int MAX_SAMP   = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  input  logic cmp_a,
  input  logic cmp_b,
  input  logic cmp_c,
  output logic ref_en,
  output logic code_a,
  output logic code_b,
  output logic code_c,
  output logic upd,
  output logic miss,
  output logic busy
);
  localparam int PW = $clog2(DIV);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int MW = $clog2(MAX_SAMP + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, UPDATE} state_t;
  state_t state_q, state_d;
  logic [2:0] sync1_q, sync2_q, cand_q, cand_d, code_q, code_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] set_q, set_d;
  logic [MW-1:0] samp_q, samp_d, match_q, match_d, match_next, samp_next;
  logic upd_q, upd_d, miss_q, miss_d, tick, fresh;
  always_comb begin
    tick = en && (pre_q == PW'(DIV - 1));
    pre_d = (en && !tick) ? pre_q + 1'b1 : '0;
    fresh = (match_q == '0) || (sync2_q != cand_q);
    match_next = fresh ? MW'(1) : match_q + 1'b1;
    samp_next = samp_q + 1'b1;
    state_d = state_q;
    set_d = set_q;
    samp_d = samp_q;
    match_d = match_q;
    cand_d = cand_q;
    code_d = code_q;
    upd_d = 1'b0;
    miss_d = 1'b0;
    // Dropping en aborts any measurement silently, taking priority over every state action.
    if (!en && state_q != IDLE) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (tick) begin
          state_d = SETTLE;
          set_d = '0;
        end
        SETTLE: begin
          set_d = set_q + 1'b1;
          if (set_q == SW'(SETTLE_CYC - 1)) begin
            state_d = SAMPLE;
            samp_d = '0;
            match_d = '0;
          end
        end
        SAMPLE: begin
          samp_d = samp_next;
          match_d = match_next;
          cand_d = fresh ? sync2_q : cand_q;
          if (match_next == MW'(STABLE_N)) state_d = UPDATE;
          else if (samp_next == MW'(MAX_SAMP)) begin
            state_d = IDLE;
            miss_d = 1'b1;
          end
        end
        UPDATE: begin
          state_d = IDLE;
          code_d = hold ? code_q : cand_q;
          upd_d = !hold;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q <= '0;
      code_q <= '0;
      pre_q <= '0;
      set_q <= '0;
      samp_q <= '0;
      match_q <= '0;
      upd_q <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= {cmp_a, cmp_b, cmp_c};
      sync2_q <= sync1_q;
      cand_q <= cand_d;
      code_q <= code_d;
      pre_q <= pre_d;
      set_q <= set_d;
      samp_q <= samp_d;
      match_q <= match_d;
      upd_q <= upd_d;
      miss_q <= miss_d;
    end
  end
  assign busy = (state_q != IDLE);
  assign ref_en = busy;
  assign {code_a, code_b, code_c} = code_q;
  assign upd = upd_q;
  assign miss = miss_q;
endmodule

// File: tb/tb_voltmeter_sample_ctrl.sv
// tb_voltmeter_sample_ctrl: directed checks of timing, debounce, timeout, hold, abort and async reset.
module tb_voltmeter_sample_ctrl;
  logic clk = 1'b0;
  logic rst, en, hold;
  logic [2:0] cmp;
  logic ref_en, code_a, code_b, code_c, upd, miss, busy;
  logic tog = 1'b0;
  int checks = 0, errors = 0, n_upd = 0, n_miss = 0;
  int n, u0, m0, hi, up;
  voltmeter_sample_ctrl #(.DIV(16), .SETTLE_CYC(4), .STABLE_N(3), .MAX_SAMP(12)) dut (
    .clk(clk), .rst(rst), .en(en), .hold(hold),
    .cmp_a(cmp[2]), .cmp_b(cmp[1]), .cmp_c(cmp[0]),
    .ref_en(ref_en), .code_a(code_a), .code_b(code_b), .code_c(code_c),
    .upd(upd), .miss(miss), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (upd === 1'b1) n_upd++;
    if (miss === 1'b1) n_miss++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    if (tog) cmp = (cmp == 3'b001) ? 3'b011 : 3'b001;
  endtask
  task automatic steps(input int k);
    repeat (k) cyc();
  endtask
  task automatic wait_ref(output int w);
    w = 0;
    while (ref_en !== 1'b1 && w < 100) begin
      cyc();
      w++;
    end
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; hold = 1'b0; cmp = 3'b111;
    steps(3);
    chk("rst_code", {29'd0, code_a, code_b, code_c}, 0);
    rst = 1'b0;
    steps(100);
    chk("idle_ref", ref_en, 0);
    chk("idle_busy", busy, 0);
    chk("idle_code", {29'd0, code_a, code_b, code_c}, 0);
    chk("idle_upd", n_upd, 0);
    chk("idle_miss", n_miss, 0);
    cmp = 3'b011; en = 1'b1;
    wait_ref(n);
    chk("first_tick", n, 16);
    chk("norm_busy", busy, 1);
    hi = 0; up = 0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      hi += int'(ref_en);
      up += int'(upd);
    end
    chk("norm_ref_hi", hi, 7);
    chk("norm_no_early_upd", up, 0);
    cyc();
    chk("norm_upd", upd, 1);
    chk("norm_code", {29'd0, code_a, code_b, code_c}, 3);
    chk("norm_ref_off", ref_en, 0);
    cyc();
    chk("norm_upd_pulse", upd, 0);
    wait_ref(n);
    chk("period", n, 7);
    steps(8);
    chk("norm2_upd", upd, 1);
    chk("norm2_code", {29'd0, code_a, code_b, code_c}, 3);
    tog = 1'b1;
    wait_ref(n);
    chk("inst_tick", n, 8);
    u0 = n_upd; m0 = n_miss;
    steps(15);
    chk("inst_no_miss_yet", miss, 0);
    chk("inst_busy", busy, 1);
    cyc();
    chk("inst_miss", miss, 1);
    chk("inst_idle", busy, 0);
    chk("inst_code", {29'd0, code_a, code_b, code_c}, 3);
    tog = 1'b0; cmp = 3'b001;
    cyc();
    chk("inst_miss_pulse", miss, 0);
    chk("inst_miss_cnt", n_miss - m0, 1);
    chk("inst_no_upd", n_upd - u0, 0);
    wait_ref(n);
    chk("late_tick", n, 15);
    steps(4);
    cmp = 3'b111;
    steps(5);
    chk("late_not_yet", upd, 0);
    chk("late_busy", busy, 1);
    cyc();
    chk("late_upd", upd, 1);
    chk("late_code", {29'd0, code_a, code_b, code_c}, 7);
    hold = 1'b1; cmp = 3'b011;
    wait_ref(n);
    chk("hold_tick", n, 6);
    chk("hold_busy", busy, 1);
    u0 = n_upd;
    steps(8);
    chk("hold_no_upd", upd, 0);
    chk("hold_code", {29'd0, code_a, code_b, code_c}, 7);
    chk("hold_ref_off", ref_en, 0);
    cyc();
    chk("hold_upd_cnt", n_upd - u0, 0);
    hold = 1'b0;
    wait_ref(n);
    chk("rel_tick", n, 7);
    steps(8);
    chk("rel_upd", upd, 1);
    chk("rel_code", {29'd0, code_a, code_b, code_c}, 3);
    wait_ref(n);
    chk("abort_tick", n, 8);
    en = 1'b0;
    u0 = n_upd; m0 = n_miss;
    cyc();
    chk("abort_ref", ref_en, 0);
    chk("abort_busy", busy, 0);
    steps(20);
    chk("abort_no_upd", n_upd - u0, 0);
    chk("abort_no_miss", n_miss - m0, 0);
    chk("abort_code", {29'd0, code_a, code_b, code_c}, 3);
    en = 1'b1;
    wait_ref(n);
    chk("rst_tick", n, 16);
    steps(5);
    chk("rst_pre_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ref", ref_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_code", {29'd0, code_a, code_b, code_c}, 0);
    chk("arst_strobes", {30'd0, upd, miss}, 0);
    cyc();
    rst = 1'b0;
    steps(3);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_code", {29'd0, code_a, code_b, code_c}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
